// File: rtl/pulser_pkg.sv
`default_nettype none
// pulser_pkg: shared channel-state encoding and default sizing for pulser_array (rev 1.0).
package pulser_pkg;

  localparam int c_def_channels = 8;
  localparam int c_def_cw       = 4;
  localparam int c_def_tw       = 8;
  localparam int c_def_dw       = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DELAY = 3'd1,
    P_HI  = 3'd2,
    DEAD  = 3'd3,
    N_HI  = 3'd4,
    PAUSE = 3'd5,
    FIN   = 3'd6
  } ch_state_e;

  function automatic int max_w(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pulser_channel.sv
`default_nettype none
// pulser_channel: one transmit channel FSM (delay, P-high, dead, N-high, pause) (rev 1.0).
module pulser_channel
  import pulser_pkg::*;
#(
  parameter int CW = c_def_cw,
  parameter int TW = c_def_tw,
  parameter int DW = c_def_dw
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          go,
  input  logic          abort,
  input  logic          all_fin,
  input  logic          enable,
  input  logic          idle_hi_nxt,
  input  logic [DW-1:0] delay,
  input  logic [CW-1:0] count,
  input  logic [TW-1:0] width,
  input  logic [TW-1:0] dead,
  input  logic [TW-1:0] pause,
  output logic          p,
  output logic          n,
  output logic          fin
);

  localparam int PW = max_w(TW, DW);

  ch_state_e     state, state_nxt;
  logic [PW-1:0] phase_cnt;
  logic [CW-1:0] pulse_cnt;
  logic [PW:0]   phase_len;
  logic          phase_last;
  logic          more_pulses;
  logic          p_nxt, n_nxt;

  always_comb begin
    phase_len = '0;
    case (state)
      DELAY:      phase_len = (PW+1)'(delay);
      P_HI, N_HI: phase_len = (PW+1)'(width);
      DEAD:       phase_len = (PW+1)'(dead);
      PAUSE:      phase_len = (PW+1)'(pause);
      default:    phase_len = '0;
    endcase
  end

  // Compare one bit wider so the last-cycle test never wraps at full-scale values.
  assign phase_last  = ({1'b0, phase_cnt} + (PW+1)'(1)) == phase_len;
  assign more_pulses = ({1'b0, pulse_cnt} + (CW+1)'(1)) < {1'b0, count};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      phase_cnt <= '0;
      pulse_cnt <= '0;
      p         <= 1'b0;
      n         <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state || state_nxt == IDLE || state_nxt == FIN)
        phase_cnt <= '0;
      else
        phase_cnt <= phase_cnt + PW'(1);
      if (state == IDLE)
        pulse_cnt <= '0;
      else if (state == N_HI && phase_last)
        pulse_cnt <= pulse_cnt + CW'(1);
      p <= p_nxt;
      n <= n_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (go) state_nxt = !enable ? FIN : (delay != '0) ? DELAY : P_HI;
      DELAY: if (phase_last) state_nxt = P_HI;
      P_HI:  if (phase_last) state_nxt = (dead != '0) ? DEAD : N_HI;
      DEAD:  if (phase_last) state_nxt = N_HI;
      N_HI:  if (phase_last) state_nxt = !more_pulses ? FIN : (pause != '0) ? PAUSE : P_HI;
      PAUSE: if (phase_last) state_nxt = P_HI;
      FIN:   if (all_fin) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  // Outputs are decoded from the next state so the drive pins are registered without extra latency.
  always_comb begin
    p_nxt = (state_nxt == P_HI) || (state_nxt == IDLE && idle_hi_nxt);
    n_nxt = (state_nxt == N_HI) || (state_nxt == IDLE && idle_hi_nxt);
  end

  assign fin = (state == FIN);

endmodule
`default_nettype wire

// File: rtl/pulser_array.sv
`default_nettype none
// pulser_array: multi-channel bipolar transmit pulser with sync, abort and busy/done (rev 1.0).
// Optional PULSER_DAMP_EN: drive p = n = 1 on all channels after a completed burst.
module pulser_array
  import pulser_pkg::*;
#(
  parameter int CHANNELS = c_def_channels,
  parameter int CW       = c_def_cw,
  parameter int TW       = c_def_tw,
  parameter int DW       = c_def_dw
) (
  input  logic                   hi_clk,
  input  logic                   rst_n,
  input  logic                   i_sync,
  input  logic                   i_abort,
  input  logic [CHANNELS-1:0]    i_tx_en,
  input  logic [CW-1:0]          i_pulse_count,
  input  logic [TW-1:0]          i_pulse_width,
  input  logic [TW-1:0]          i_dead_time,
  input  logic [TW-1:0]          i_pulse_pause,
  input  logic [CHANNELS*DW-1:0] i_delay,
  output logic [CHANNELS-1:0]    o_pulse_p,
  output logic [CHANNELS-1:0]    o_pulse_n,
  output logic                   o_busy,
  output logic                   o_done
);

  logic                   sync_meta, sync_s, sync_d;
  logic                   start, accept, abort_hit, all_fin;
  logic                   go, busy, done;
  logic                   idle_hi_nxt;
  logic [CHANNELS-1:0]    fin_vec;
  logic [CHANNELS-1:0]    tx_en_q;
  logic [CW-1:0]          count_q;
  logic [TW-1:0]          width_q, dead_q, pause_q;
  logic [CHANNELS*DW-1:0] delay_q;

  always_ff @(posedge hi_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta <= 1'b0;
      sync_s    <= 1'b0;
      sync_d    <= 1'b0;
    end else begin
      sync_meta <= i_sync;
      sync_s    <= sync_meta;
      sync_d    <= sync_s;
    end
  end

  assign start     = sync_s & ~sync_d;
  assign accept    = start & ~busy & ~i_abort & (i_pulse_count != '0) & (i_pulse_width != '0);
  assign abort_hit = i_abort & busy;
  assign all_fin   = &fin_vec;

  always_ff @(posedge hi_clk or negedge rst_n) begin
    if (!rst_n) begin
      go      <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      tx_en_q <= '0;
      count_q <= '0;
      width_q <= '0;
      dead_q  <= '0;
      pause_q <= '0;
      delay_q <= '0;
    end else begin
      go   <= accept;
      done <= all_fin & ~abort_hit;
      if (abort_hit)
        busy <= 1'b0;
      else if (accept)
        busy <= 1'b1;
      else if (done)
        busy <= 1'b0;
      if (accept) begin
        tx_en_q <= i_tx_en;
        count_q <= i_pulse_count;
        width_q <= i_pulse_width;
        dead_q  <= i_dead_time;
        pause_q <= i_pulse_pause;
        delay_q <= i_delay;
      end
    end
  end

`ifdef PULSER_DAMP_EN
  logic idle_hi;

  // Damp level arms on completion and is dropped by a new burst or any abort.
  always_comb begin
    idle_hi_nxt = idle_hi;
    if (i_abort || accept)
      idle_hi_nxt = 1'b0;
    else if (all_fin)
      idle_hi_nxt = 1'b1;
  end

  always_ff @(posedge hi_clk or negedge rst_n) begin
    if (!rst_n)
      idle_hi <= 1'b0;
    else
      idle_hi <= idle_hi_nxt;
  end
`else
  assign idle_hi_nxt = 1'b0;
`endif

  generate
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      pulser_channel #(
        .CW (CW),
        .TW (TW),
        .DW (DW)
      ) u_ch (
        .clk         (hi_clk),
        .rst_n       (rst_n),
        .go          (go),
        .abort       (abort_hit),
        .all_fin     (all_fin),
        .enable      (tx_en_q[i]),
        .idle_hi_nxt (idle_hi_nxt),
        .delay       (delay_q[i*DW +: DW]),
        .count       (count_q),
        .width       (width_q),
        .dead        (dead_q),
        .pause       (pause_q),
        .p           (o_pulse_p[i]),
        .n           (o_pulse_n[i]),
        .fin         (fin_vec[i])
      );
    end
  endgenerate

  assign o_busy = busy;
  assign o_done = done;

endmodule
`default_nettype wire

// File: tb/tb_pulser_array.sv
`default_nettype none
// tb_pulser_array: directed self-checking bench for pulser_array.
module tb_pulser_array;

  localparam int NCH = 8;

  logic           hi_clk = 1'b0;
  logic           rst_n;
  logic           i_sync;
  logic           i_abort;
  logic [7:0]     i_tx_en;
  logic [3:0]     i_pulse_count;
  logic [7:0]     i_pulse_width;
  logic [7:0]     i_dead_time;
  logic [7:0]     i_pulse_pause;
  logic [63:0]    i_delay;
  logic [7:0]     o_pulse_p;
  logic [7:0]     o_pulse_n;
  logic           o_busy;
  logic           o_done;

  int n_cmp = 0;
  int n_bad = 0;

  int         cfg_n, cfg_w, cfg_d, cfg_p;
  int         cfg_dly [NCH];
  logic [7:0] cfg_en;
  logic       damp;
  logic [7:0] idle_lvl;

  pulser_array dut (
    .hi_clk        (hi_clk),
    .rst_n         (rst_n),
    .i_sync        (i_sync),
    .i_abort       (i_abort),
    .i_tx_en       (i_tx_en),
    .i_pulse_count (i_pulse_count),
    .i_pulse_width (i_pulse_width),
    .i_dead_time   (i_dead_time),
    .i_pulse_pause (i_pulse_pause),
    .i_delay       (i_delay),
    .o_pulse_p     (o_pulse_p),
    .o_pulse_n     (o_pulse_n),
    .o_busy        (o_busy),
    .o_done        (o_done)
  );

  always #5 hi_clk = ~hi_clk;

  task automatic tick();
    @(posedge hi_clk);
    #1;
  endtask

  task automatic apply_cfg(input logic [7:0] en, input int n, input int w, input int d,
                           input int p, input int d0, input int d1);
    cfg_en = en; cfg_n = n; cfg_w = w; cfg_d = d; cfg_p = p;
    for (int c = 0; c < NCH; c++) cfg_dly[c] = 0;
    cfg_dly[0] = d0;
    cfg_dly[1] = d1;
    i_tx_en       = en;
    i_pulse_count = 4'(n);
    i_pulse_width = 8'(w);
    i_dead_time   = 8'(d);
    i_pulse_pause = 8'(p);
    for (int c = 0; c < NCH; c++) i_delay[c*8 +: 8] = 8'(cfg_dly[c]);
  endtask

  function automatic int burst_len(input int c);
    if (!cfg_en[c]) return 0;
    return cfg_dly[c] + cfg_n * (2 * cfg_w + cfg_d) + (cfg_n - 1) * cfg_p;
  endfunction

  function automatic int last_len();
    int m = 0;
    for (int c = 0; c < NCH; c++) if (burst_len(c) > m) m = burst_len(c);
    return m;
  endfunction

  // Reference {p,n} for channel c, u cycles after the channels leave IDLE.
  function automatic logic [1:0] exp_pn(input int u, input int c);
    int v;
    if (u < 0) return 2'b00;
    if (u >= last_len() + 1) return {damp, damp};
    if (!cfg_en[c]) return 2'b00;
    v = u - cfg_dly[c];
    if (v < 0 || v >= burst_len(c) - cfg_dly[c]) return 2'b00;
    v = v % (2 * cfg_w + cfg_d + cfg_p);
    if (v < cfg_w) return 2'b10;
    if (v < cfg_w + cfg_d) return 2'b00;
    if (v < 2 * cfg_w + cfg_d) return 2'b01;
    return 2'b00;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; i_sync = 1'b0; i_abort = 1'b0;
    apply_cfg(8'h00, 0, 0, 0, 0, 0, 0);
    repeat (3) tick();
    n_cmp++; if (o_pulse_p !== 8'h00) begin n_bad++; $display("FAIL reset_p got %h want 00", o_pulse_p); end
    n_cmp++; if (o_pulse_n !== 8'h00) begin n_bad++; $display("FAIL reset_n got %h want 00", o_pulse_n); end
    n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", o_busy); end
    n_cmp++; if (o_done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", o_done); end
    rst_n = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_burst();
    int u, first_p, done_at, lim;
    logic [1:0] pn;
    logic [7:0] ep, en;
    apply_cfg(8'h01, 2, 3, 1, 2, 0, 0);
    first_p = -99; done_at = -99; lim = last_len() + 8;
    i_sync = 1'b1;
    for (int t = 1; t <= lim; t++) begin
      tick();
      if (t == 5) i_sync = 1'b0;
      u = t - 4;
      for (int c = 0; c < NCH; c++) begin pn = exp_pn(u, c); ep[c] = pn[1]; en[c] = pn[0]; end
      if (t >= 3) begin
        n_cmp++; if (o_pulse_p !== ep) begin n_bad++; $display("FAIL burst_p u=%0d got %h want %h", u, o_pulse_p, ep); end
        n_cmp++; if (o_pulse_n !== en) begin n_bad++; $display("FAIL burst_n u=%0d got %h want %h", u, o_pulse_n, en); end
        n_cmp++; if (o_busy !== (u <= last_len() + 1)) begin n_bad++; $display("FAIL burst_busy u=%0d got %b", u, o_busy); end
        n_cmp++; if (o_done !== (u == last_len() + 1)) begin n_bad++; $display("FAIL burst_done u=%0d got %b", u, o_done); end
        if (o_pulse_p[0] && first_p == -99) first_p = u;
        if (o_done && done_at == -99) done_at = u;
      end
    end
    n_cmp++; if (first_p !== 0) begin n_bad++; $display("FAIL burst_first_p got %0d want 0", first_p); end
    n_cmp++; if (done_at !== 17) begin n_bad++; $display("FAIL burst_done_at got %0d want 17", done_at); end
  endtask

  task automatic test_delay();
    int u, p0, p1, n1, done_at, lim;
    logic [1:0] pn;
    logic [7:0] ep, en;
    apply_cfg(8'h03, 1, 2, 0, 3, 0, 5);
    p0 = -99; p1 = -99; n1 = -99; done_at = -99; lim = last_len() + 8;
    i_sync = 1'b1;
    for (int t = 1; t <= lim; t++) begin
      tick();
      if (t == 5) i_sync = 1'b0;
      u = t - 4;
      for (int c = 0; c < NCH; c++) begin pn = exp_pn(u, c); ep[c] = pn[1]; en[c] = pn[0]; end
      if (t >= 3) begin
        n_cmp++; if (o_pulse_p !== ep) begin n_bad++; $display("FAIL delay_p u=%0d got %h want %h", u, o_pulse_p, ep); end
        n_cmp++; if (o_pulse_n !== en) begin n_bad++; $display("FAIL delay_n u=%0d got %h want %h", u, o_pulse_n, en); end
        n_cmp++; if (o_done !== (u == last_len() + 1)) begin n_bad++; $display("FAIL delay_done u=%0d got %b", u, o_done); end
        if (o_pulse_p[0] && p0 == -99) p0 = u;
        if (o_pulse_p[1] && p1 == -99) p1 = u;
        if (o_pulse_n[1] && n1 == -99) n1 = u;
        if (o_done && done_at == -99) done_at = u;
      end
    end
    n_cmp++; if (p1 - p0 !== 5) begin n_bad++; $display("FAIL delay_offset got %0d want 5", p1 - p0); end
    n_cmp++; if (n1 !== 7) begin n_bad++; $display("FAIL delay_n_follow got %0d want 7", n1); end
    n_cmp++; if (done_at !== 10) begin n_bad++; $display("FAIL delay_done_at got %0d want 10", done_at); end
  endtask

  task automatic test_ignore();
    for (int k = 0; k < 2; k++) begin
      if (k == 0) apply_cfg(8'hFF, 0, 3, 1, 2, 0, 0);
      else        apply_cfg(8'hFF, 2, 0, 1, 2, 0, 0);
      i_sync = 1'b1;
      for (int t = 1; t <= 12; t++) begin
        tick();
        if (t == 5) i_sync = 1'b0;
        n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL ignore_busy k=%0d t=%0d got %b want 0", k, t, o_busy); end
        n_cmp++; if (o_pulse_p !== idle_lvl) begin n_bad++; $display("FAIL ignore_p k=%0d t=%0d got %h want %h", k, t, o_pulse_p, idle_lvl); end
        n_cmp++; if (o_pulse_n !== idle_lvl) begin n_bad++; $display("FAIL ignore_n k=%0d t=%0d got %h want %h", k, t, o_pulse_n, idle_lvl); end
      end
    end
  endtask

  task automatic test_back_to_back();
    int u, ndone, lim;
    logic [1:0] pn;
    logic [7:0] ep, en;
    apply_cfg(8'h01, 2, 3, 1, 2, 0, 0);
    ndone = 0; lim = last_len() + 10;
    i_sync = 1'b1;
    for (int t = 1; t <= lim; t++) begin
      tick();
      if (t == 5)  i_sync = 1'b0;
      if (t == 8)  i_sync = 1'b1;
      if (t == 12) i_sync = 1'b0;
      u = t - 4;
      for (int c = 0; c < NCH; c++) begin pn = exp_pn(u, c); ep[c] = pn[1]; en[c] = pn[0]; end
      if (t >= 3) begin
        n_cmp++; if (o_pulse_p !== ep) begin n_bad++; $display("FAIL retrig_p u=%0d got %h want %h", u, o_pulse_p, ep); end
        n_cmp++; if (o_pulse_n !== en) begin n_bad++; $display("FAIL retrig_n u=%0d got %h want %h", u, o_pulse_n, en); end
      end
      if (o_done) ndone++;
    end
    n_cmp++; if (ndone !== 1) begin n_bad++; $display("FAIL retrig_done_count got %0d want 1", ndone); end
  endtask

  task automatic test_abort();
    int ndone, done_at, first_p;
    apply_cfg(8'h01, 2, 3, 1, 2, 0, 0);
    i_sync = 1'b1;
    for (int t = 1; t <= 8; t++) begin
      tick();
      if (t == 5) i_sync = 1'b0;
    end
    n_cmp++; if (o_pulse_n !== 8'h01) begin n_bad++; $display("FAIL abort_in_nhi got %h want 01", o_pulse_n); end
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    n_cmp++; if (o_pulse_p !== 8'h00) begin n_bad++; $display("FAIL abort_p got %h want 00", o_pulse_p); end
    n_cmp++; if (o_pulse_n !== 8'h00) begin n_bad++; $display("FAIL abort_n got %h want 00", o_pulse_n); end
    n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy got %b want 0", o_busy); end
    ndone = 0;
    for (int t = 0; t < 20; t++) begin
      tick();
      if (o_done) ndone++;
      n_cmp++; if (o_pulse_p !== 8'h00) begin n_bad++; $display("FAIL abort_quiet_p t=%0d got %h want 00", t, o_pulse_p); end
    end
    n_cmp++; if (ndone !== 0) begin n_bad++; $display("FAIL abort_no_done got %0d want 0", ndone); end
    done_at = -99; first_p = -99;
    i_sync = 1'b1;
    for (int t = 1; t <= 26; t++) begin
      tick();
      if (t == 5) i_sync = 1'b0;
      if (t >= 3 && o_pulse_p[0] && first_p == -99) first_p = t - 4;
      if (o_done && done_at == -99) done_at = t - 4;
    end
    n_cmp++; if (first_p !== 0) begin n_bad++; $display("FAIL abort_retry_p got %0d want 0", first_p); end
    n_cmp++; if (done_at !== 17) begin n_bad++; $display("FAIL abort_retry_done got %0d want 17", done_at); end
  endtask

  task automatic test_reset_mid();
    apply_cfg(8'hFF, 2, 3, 1, 2, 0, 0);
    i_sync = 1'b1;
    for (int t = 1; t <= 9; t++) begin
      tick();
      if (t == 5) i_sync = 1'b0;
    end
    n_cmp++; if (o_pulse_n !== 8'hFF) begin n_bad++; $display("FAIL rstmid_pre got %h want ff", o_pulse_n); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (o_pulse_p !== 8'h00) begin n_bad++; $display("FAIL rstmid_p got %h want 00", o_pulse_p); end
    n_cmp++; if (o_pulse_n !== 8'h00) begin n_bad++; $display("FAIL rstmid_n got %h want 00", o_pulse_n); end
    n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy got %b want 0", o_busy); end
    tick();
    rst_n = 1'b1;
    repeat (6) tick();
    n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_after_busy got %b want 0", o_busy); end
    n_cmp++; if (o_pulse_p !== 8'h00) begin n_bad++; $display("FAIL rstmid_after_p got %h want 00", o_pulse_p); end
  endtask

  initial begin
`ifdef PULSER_DAMP_EN
    damp = 1'b1;
`else
    damp = 1'b0;
`endif
    idle_lvl = {8{damp}};
    test_reset();
    test_burst();
    repeat (4) tick();
    test_delay();
    repeat (4) tick();
    test_ignore();
    test_back_to_back();
    repeat (4) tick();
    test_abort();
    repeat (4) tick();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
